// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// pipe_ctrl_if : stall/flush handshake bundle between pipeline stages and
//                the pipeline sequencing controller.
// Revision     : 1.0
// ============================================================================
interface pipe_ctrl_if #(
    parameter int MC_CNT_W = 6,
    parameter int PC_W     = 32
);
    logic                stallreq_id;
    logic                stallreq_ex;
    logic                stallreq_mem;
    logic                mc_start;
    logic [MC_CNT_W-1:0] mc_cycles;
    logic                flush_req;
    logic [PC_W-1:0]     flush_pc;
    logic [5:0]          stall;
    logic                flush;
    logic [PC_W-1:0]     new_pc;
    logic                mc_busy;
    logic                mc_done;
    logic [31:0]         stall_cycles;

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem, mc_start, mc_cycles,
               flush_req, flush_pc,
        input  stall, flush, new_pc, mc_busy, mc_done, stall_cycles
    );

    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem, mc_start, mc_cycles,
               flush_req, flush_pc,
        output stall, flush, new_pc, mc_busy, mc_done, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_ctrl : five-stage pipeline stall/flush sequencer with multi-cycle EX
//             handshake. Optional stall statistics: PIPE_CTRL_STALL_STATS_EN.
// Revision  : 1.0
// ============================================================================
module pipe_ctrl #(
    parameter int MC_CNT_W = 6,
    parameter int PC_W     = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    pipe_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MC    = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [MC_CNT_W-1:0] r_cnt;
    logic [MC_CNT_W-1:0] w_cnt_next;
    logic [PC_W-1:0]     r_new_pc;
    logic [PC_W-1:0]     w_pc_next;
    logic                w_mc_accept;
    logic [5:0]          w_stall;

    assign w_mc_accept = (r_state == S_IDLE) && bus.mc_start &&
                         (bus.mc_cycles != '0) && !bus.flush_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_new_pc <= '0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_next;
            r_new_pc <= w_pc_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_pc_next  = r_new_pc;
        if (bus.flush_req) begin
            // A redirect overrides everything, including an in-flight MC op.
            w_next     = S_FLUSH;
            w_cnt_next = '0;
            w_pc_next  = bus.flush_pc;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mc_accept) begin
                        w_next     = S_MC;
                        w_cnt_next = bus.mc_cycles;
                    end
                end
                S_MC: begin
                    w_cnt_next = r_cnt - MC_CNT_W'(1);
                    if (r_cnt == MC_CNT_W'(1)) begin
                        w_next = S_IDLE;
                    end
                end
                S_FLUSH: begin
                    w_next = S_IDLE;
                end
                default: begin
                    w_next     = S_IDLE;
                    w_cnt_next = '0;
                end
            endcase
        end
    end

    // Deeper stage requests win: each hold also freezes every earlier stage.
    always_comb begin
        w_stall = 6'b000000;
        if (!rst || bus.flush_req || (r_state == S_FLUSH)) begin
            w_stall = 6'b000000;
        end else if (bus.stallreq_mem) begin
            w_stall = 6'b011111;
        end else if (bus.stallreq_ex || (r_state == S_MC) || w_mc_accept) begin
            w_stall = 6'b001111;
        end else if (bus.stallreq_id) begin
            w_stall = 6'b000111;
        end
    end

    assign bus.stall   = w_stall;
    assign bus.flush   = (r_state == S_FLUSH);
    assign bus.new_pc  = r_new_pc;
    assign bus.mc_busy = (r_state == S_MC);
    assign bus.mc_done = (r_state == S_MC) && (r_cnt == MC_CNT_W'(1));

`ifdef PIPE_CTRL_STALL_STATS_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= 32'd0;
        end else if (w_stall[0] && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
`else
    assign bus.stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire
